pipe_track: RTL

//  Pipeline tracking registers that feed the forwarding unit.
//  - Carries each decoded instruction's destination info (rd, opcode, regwe, valid) through two slots, EX then WB.
//  - EX slot drives old_rd / old_opcode; WB slot drives older_rd / older_regwe.
//  - Owns the pipeline stall and flush sequencing, so a stall freezes the tracked state and a redirect inserts bubbles.

---
 rtl/pipe_track_pkg.sv | 22 ++
 rtl/pipe_track_slot.sv | 69 ++++++
 rtl/pipe_track.sv | 125 ++++++++++++
 3 files changed

// File: rtl/pipe_track_pkg.sv
// rtl/pipe_track_pkg.sv - opcode constants and FSM encodings shared by the pipe tracker
package pipe_track_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'h03;
    localparam logic [6:0] OPC_ARI_ITYPE = 7'h13;
    localparam logic [6:0] OPC_AUIPC     = 7'h17;
    localparam logic [6:0] OPC_STORE     = 7'h23;
    localparam logic [6:0] OPC_ARI_RTYPE = 7'h33;
    localparam logic [6:0] OPC_LUI       = 7'h37;
    localparam logic [6:0] OPC_BRANCH    = 7'h63;
    localparam logic [6:0] OPC_JALR      = 7'h67;
    localparam logic [6:0] OPC_JAL       = 7'h6f;

    localparam logic [6:0] NOP_OPC_DEFAULT = OPC_ARI_ITYPE;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_STALL = 2'd2
    } st_e;

endpackage

// File: rtl/pipe_track_slot.sv
// rtl/pipe_track_slot.sv - one tracked pipeline slot (rd/opcode/regwe/valid) with hold and bubble load
module pipe_slot
    import pipe_track_pkg::*;
#(
    parameter int         RF_AW   = 5,
    parameter int         OPC_W   = 7,
    parameter logic [6:0] NOP_OPC = NOP_OPC_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             hold,
    input  logic             load_bubble,
    input  logic             d_valid,
    input  logic [RF_AW-1:0] d_rd,
    input  logic [OPC_W-1:0] d_opcode,
    input  logic             d_regwe,
    output logic             valid,
    output logic [RF_AW-1:0] rd,
    output logic [OPC_W-1:0] opcode,
    output logic             regwe
);

    localparam logic [OPC_W-1:0] BUBBLE_OPC = OPC_W'(NOP_OPC);

    logic             valid_q, valid_d;
    logic [RF_AW-1:0] rd_q, rd_d;
    logic [OPC_W-1:0] opcode_q, opcode_d;
    logic             regwe_q, regwe_d;

    always_comb begin
        valid_d  = valid_q;
        rd_d     = rd_q;
        opcode_d = opcode_q;
        regwe_d  = regwe_q;
        if (!hold) begin
            if (load_bubble) begin
                valid_d  = 1'b0;
                rd_d     = '0;
                opcode_d = BUBBLE_OPC;
                regwe_d  = 1'b0;
            end else begin
                valid_d  = d_valid;
                rd_d     = d_rd;
                opcode_d = d_opcode;
                regwe_d  = d_regwe;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q  <= 1'b0;
            rd_q     <= '0;
            opcode_q <= BUBBLE_OPC;
            regwe_q  <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            rd_q     <= rd_d;
            opcode_q <= opcode_d;
            regwe_q  <= regwe_d;
        end
    end

    assign valid  = valid_q;
    assign rd     = rd_q;
    assign opcode = opcode_q;
    assign regwe  = regwe_q;

endmodule

// File: rtl/pipe_track.sv
// rtl/pipe_track.sv - EX/WB destination tracking with stall/flush sequencing for the forwarding unit
module pipe_track
    import pipe_track_pkg::*;
#(
    parameter int         RF_AW   = 5,
    parameter int         OPC_W   = 7,
    parameter logic [6:0] NOP_OPC = NOP_OPC_DEFAULT,
    parameter int         FLUSH_N = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             id_valid,
    input  logic [RF_AW-1:0] id_rd,
    input  logic [OPC_W-1:0] id_opcode,
    input  logic             id_regwe,
    input  logic             stall_req,
    input  logic             redirect,
    output logic             id_hold,
    output logic             ex_valid,
    output logic [RF_AW-1:0] ex_rd,
    output logic [OPC_W-1:0] ex_opcode,
    output logic             ex_regwe,
    output logic             wb_valid,
    output logic [RF_AW-1:0] wb_rd,
    output logic             wb_regwe,
    output logic             flushing
);

    localparam logic [1:0] FLUSH_RELOAD = 2'(FLUSH_N - 1);

    st_e        state_q, state_d;
    logic [1:0] flush_cnt_q, flush_cnt_d;
    logic       pend_q, pend_d;
    logic       pre_state_q, pre_state_d;
    logic       slot_hold, ex_bubble;
    logic       eff_flush, do_redirect;
    logic [OPC_W-1:0] wb_opcode_unused;
    logic             wb_regwe_raw;

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = flush_cnt_q;
        pend_d      = pend_q;
        pre_state_d = pre_state_q;
        slot_hold   = 1'b0;
        ex_bubble   = 1'b0;
        // A stall release acts as one cycle of the pre-stall state, with any latched redirect applied.
        eff_flush   = (state_q == ST_FLUSH) || ((state_q == ST_STALL) && pre_state_q);
        do_redirect = redirect || ((state_q == ST_STALL) && pend_q);

        if (stall_req) begin
            slot_hold = 1'b1;
            state_d   = ST_STALL;
            if (state_q != ST_STALL) begin
                pre_state_d = (state_q == ST_FLUSH);
                pend_d      = redirect;
            end else begin
                pend_d = pend_q | redirect;
            end
        end else begin
            pend_d = 1'b0;
            if (do_redirect) begin
                ex_bubble   = 1'b1;
                flush_cnt_d = FLUSH_RELOAD;
                state_d     = (FLUSH_N > 1) ? ST_FLUSH : ST_RUN;
            end else if (eff_flush) begin
                ex_bubble   = 1'b1;
                flush_cnt_d = (flush_cnt_q != 2'd0) ? flush_cnt_q - 2'd1 : 2'd0;
                state_d     = (flush_cnt_q <= 2'd1) ? ST_RUN : ST_FLUSH;
            end else begin
                ex_bubble = !id_valid;
                state_d   = ST_RUN;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_RUN;
            flush_cnt_q <= 2'd0;
            pend_q      <= 1'b0;
            pre_state_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
            pend_q      <= pend_d;
            pre_state_q <= pre_state_d;
        end
    end

    pipe_slot #(.RF_AW(RF_AW), .OPC_W(OPC_W), .NOP_OPC(NOP_OPC)) u_ex (
        .clk         (clk),
        .rst         (rst),
        .hold        (slot_hold),
        .load_bubble (ex_bubble),
        .d_valid     (id_valid),
        .d_rd        (id_rd),
        .d_opcode    (id_opcode),
        .d_regwe     (id_regwe),
        .valid       (ex_valid),
        .rd          (ex_rd),
        .opcode      (ex_opcode),
        .regwe       (ex_regwe)
    );

    pipe_slot #(.RF_AW(RF_AW), .OPC_W(OPC_W), .NOP_OPC(NOP_OPC)) u_wb (
        .clk         (clk),
        .rst         (rst),
        .hold        (slot_hold),
        .load_bubble (1'b0),
        .d_valid     (ex_valid),
        .d_rd        (ex_rd),
        .d_opcode    (ex_opcode),
        .d_regwe     (ex_regwe),
        .valid       (wb_valid),
        .rd          (wb_rd),
        .opcode      (wb_opcode_unused),
        .regwe       (wb_regwe_raw)
    );

    assign wb_regwe = wb_regwe_raw & wb_valid;
    assign id_hold  = stall_req;
    assign flushing = (state_q == ST_FLUSH);

endmodule
